// File: rtl/imem_fetch_ctrl_if.sv
// Fetch and program-load bundle for imem_fetch_ctrl.
// master = fetch stage plus loader, slave = instruction memory.
interface imem_fetch_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic              rsp_fault;
   logic              load_mode;
   logic              load_we;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic [15:0]       load_count;

   modport master (
      output fetch_req,
      output fetch_addr,
      output rsp_ready,
      output load_mode,
      output load_we,
      output load_addr,
      output load_data,
      input  fetch_ready,
      input  rsp_valid,
      input  rsp_instr,
      input  rsp_fault,
      input  load_count
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      input  rsp_ready,
      input  load_mode,
      input  load_we,
      input  load_addr,
      input  load_data,
      output fetch_ready,
      output rsp_valid,
      output rsp_instr,
      output rsp_fault,
      output load_count
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with a registered valid/ready fetch port and a
// runtime program-load port. Optional macro: IMEM_BOUNDS_CHECK_EN.
module imem_fetch_ctrl #(
   parameter int                DATA_W    = 16,
   parameter int                DEPTH     = 512,
   parameter int                ADDR_W    = 16,
   parameter logic [DATA_W-1:0] HALT_WORD = 16'hF000
) (
   input logic             clk,
   input logic             rst_n,
   imem_fetch_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   // Reject geometries the index rule cannot represent.
   if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if (ADDR_W < IDX_W) begin : g_bad_addr
      $error("ADDR_W too narrow for DEPTH");
   end

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } state_t;

   state_t              state;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_instr_q;
   logic                rsp_fault_q;
   logic [15:0]         load_count_q;

   // Storage powers up holding HALT_WORD; it has no reset so that a
   // mid-run reset keeps the loaded program.
   logic [DATA_W-1:0]   mem [DEPTH] = '{default: HALT_WORD};

   logic [IDX_W-1:0]    rd_idx;
   logic [IDX_W-1:0]    wr_idx;
   logic                rd_oob;
   logic                wr_oob;
   logic [DATA_W-1:0]   rd_word;
   logic                accept;
   logic                wr_en;
   logic                unused_addr;

   assign rd_idx = bus.fetch_addr[IDX_W-1:0];
   assign wr_idx = bus.load_addr[IDX_W-1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
   // Any address bit above the index field means past the end.
   assign rd_oob = (bus.fetch_addr >> IDX_W) != '0;
   assign wr_oob = (bus.load_addr >> IDX_W) != '0;
`else
   // Addresses wrap modulo DEPTH, so nothing is ever out of range.
   assign rd_oob = 1'b0;
   assign wr_oob = 1'b0;
`endif

   // High address bits only matter when bounds checking is built in.
   assign unused_addr = ^{bus.fetch_addr, bus.load_addr};

   // Faulting fetches never touch the array.
   assign rd_word = rd_oob ? HALT_WORD : mem[rd_idx];

   // Ready only in RUN with the output slot free and no load pending;
   // forced low while reset is asserted.
   assign bus.fetch_ready = rst_n
                          && (state == RUN)
                          && (!rsp_valid_q || bus.rsp_ready)
                          && !bus.load_mode;

   assign accept = bus.fetch_req && bus.fetch_ready;

   assign wr_en = (state == LOAD) && bus.load_we && !wr_oob;

   // Loader writes; the word is visible to the next accepted fetch.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= bus.load_data;
      end
   end

   // Mode FSM with the registered response slot and load counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         rsp_valid_q  <= 1'b0;
         rsp_instr_q  <= '0;
         rsp_fault_q  <= 1'b0;
         load_count_q <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (accept) begin
                  rsp_valid_q <= 1'b1;
                  rsp_instr_q <= rd_word;
                  rsp_fault_q <= rd_oob;
               end else if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
               end
               if (bus.load_mode) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (rsp_valid_q && bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
               end
               if (!bus.load_mode) begin
                  state <= RUN;
               end else if (!rsp_valid_q || bus.rsp_ready) begin
                  state        <= LOAD;
                  load_count_q <= '0;
               end
            end
            LOAD: begin
               if (wr_en && load_count_q != 16'hFFFF) begin
                  load_count_q <= load_count_q + 16'd1;
               end
               if (!bus.load_mode) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_instr  = rsp_instr_q;
   assign bus.rsp_fault  = rsp_fault_q;
   assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized self-checking bench for imem_fetch_ctrl.
// Reference: word array plus a one-slot response model.
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 512;
   localparam int AW    = 16;
   localparam int DW    = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   imem_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   imem_fetch_ctrl #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .ADDR_W   (AW),
      .HALT_WORD(16'hF000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [15:0] mmem [DEPTH];
   int          n_chk = 0;
   int          n_err = 0;
   logic        m_valid = 1'b0;
   logic [15:0] m_instr = '0;
   logic        m_fault = 1'b0;
   int          m_count = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] ref_read(input logic [15:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
      if (int'(a) >= DEPTH) return {1'b1, 16'hF000};
`endif
      return {1'b0, mmem[int'(a) % DEPTH]};
   endfunction

   function automatic bit ref_wr_ok(input logic [15:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
      return int'(a) < DEPTH;
`else
      return (a == a);
`endif
   endfunction

   // One RUN-mode cycle: drive, check at negedge, advance model.
   task automatic cycle(input logic req, input logic [15:0] addr,
                        input logic rdy);
      logic [16:0] r;
      logic        exp_rdy;
      bus.fetch_req  = req;
      bus.fetch_addr = addr;
      bus.rsp_ready  = rdy;
      @(negedge clk);
      exp_rdy = !m_valid || rdy;
      chk("fetch_ready", bus.fetch_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, m_valid);
      if (m_valid) begin
         chk("rsp_instr", bus.rsp_instr, m_instr);
         chk("rsp_fault", bus.rsp_fault, m_fault);
      end
      if (req && exp_rdy) begin
         r       = ref_read(addr);
         m_valid = 1'b1;
         m_instr = r[15:0];
         m_fault = r[16];
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic enter_load();
      bus.load_mode = 1'b1;
      bus.fetch_req = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("ready_loadmode", bus.fetch_ready, 1'b0);
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk("ready_drain", bus.fetch_ready, 1'b0);
      chk("valid_drain", bus.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      m_count = 0;
      @(negedge clk);
      chk("count_entry", bus.load_count, 16'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.load_we   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      @(posedge clk);
      #1;
      bus.load_we = 1'b0;
      if (ref_wr_ok(a)) begin
         mmem[int'(a) % DEPTH] = d;
         if (m_count < 65535) m_count++;
      end
      @(negedge clk);
      chk("load_count", bus.load_count, m_count[15:0]);
      chk("ready_load", bus.fetch_ready, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic exit_load();
      bus.load_mode = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 16'($urandom_range(512, 1023));
      return 16'($urandom_range(0, 31));
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) mmem[i] = 16'hF000;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = '0;
      bus.rsp_ready  = 1'b1;
      bus.load_mode  = 1'b0;
      bus.load_we    = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", bus.rsp_valid, 1'b0);
      chk("rst_instr", bus.rsp_instr, 16'h0);
      chk("rst_fault", bus.rsp_fault, 1'b0);
      chk("rst_count", bus.load_count, 16'h0);
      chk("rst_ready", bus.fetch_ready, 1'b0);
      bus.fetch_req = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cycle(1'b0, 16'd0, 1'b1);
      chk("idle_instr", bus.rsp_instr, 16'h0);
      chk("idle_count", bus.load_count, 16'h0);
      cycle(1'b1, 16'd5, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      enter_load();
      wr(16'd0, 16'h0298);
      wr(16'd1, 16'h5805);
      wr(16'd2, 16'hF000);
      exit_load();
      cycle(1'b1, 16'd0, 1'b1);
      cycle(1'b1, 16'd1, 1'b1);
      cycle(1'b1, 16'd2, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);
      chk("count_after", bus.load_count, 16'd3);

      cycle(1'b1, 16'd1, 1'b1);
      repeat (3) cycle(1'b1, 16'd0, 1'b0);
      cycle(1'b1, 16'd2, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      cycle(1'b1, 16'd512, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      // Response stalled while load_mode rises: DRAIN holds.
      cycle(1'b1, 16'd1, 1'b0);
      bus.fetch_req = 1'b0;
      bus.load_mode = 1'b1;
      bus.load_we   = 1'b1;
      bus.load_addr = 16'd7;
      bus.load_data = 16'h1234;
      repeat (3) begin
         @(negedge clk);
         chk("drain_ready", bus.fetch_ready, 1'b0);
         chk("drain_valid", bus.rsp_valid, 1'b1);
         chk("drain_instr", bus.rsp_instr, 16'h5805);
         @(posedge clk);
         #1;
      end
      bus.load_we   = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain_done", bus.rsp_valid, 1'b0);
      chk("drain_cnt", bus.load_count, 16'd0);
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      exit_load();
      cycle(1'b1, 16'd7, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      // Reset in the middle of a load session.
      enter_load();
      wr(16'd20, 16'h1111);
      wr(16'd21, 16'h2222);
      bus.load_mode = 1'b0;
      bus.fetch_req = 1'b1;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", bus.rsp_valid, 1'b0);
      chk("mid_rst_instr", bus.rsp_instr, 16'h0);
      chk("mid_rst_count", bus.load_count, 16'h0);
      chk("mid_rst_ready", bus.fetch_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.fetch_req = 1'b0;
      m_valid = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 16'd20, 1'b1);
      cycle(1'b1, 16'd21, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      repeat (6) begin
         enter_load();
         repeat ($urandom_range(3, 10)) wr(rnd_addr(), 16'($urandom));
         exit_load();
         repeat (80) begin
            cycle(1'($urandom_range(0, 9) < 7), rnd_addr(),
                  1'($urandom_range(0, 9) < 6));
         end
      end
      cycle(1'b0, 16'd0, 1'b1);
      cycle(1'b0, 16'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Parametrised instruction memory with a registered fetch port and a program-load port.
- Replaces the fixed 512x16 combinational ROM.
- Sits between the PC/fetch stage and the decode stage.
- Fetch uses a valid/ready handshake with 1-cycle read latency and stall hold.
- A loader (boot/debug path) writes program words at runtime; fetch is blocked while loading.

Parameters:
DATA_W, 16, instruction width in bits
DEPTH, 512, number of instruction words (power of two, >=2)
ADDR_W, 16, width of fetch/load address (word address), ADDR_W >= log2(DEPTH)
HALT_WORD, 16'hF000, word returned on fault and used as memory init value

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request valid
fetch_addr  in  ADDR_W  word address to fetch
fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready
rsp_valid  out  1  rsp_instr/rsp_fault valid
rsp_ready  in  1  decode can take response; low = stall
rsp_instr  out  DATA_W  fetched instruction
rsp_fault  out  1  address fault flag for this response
load_mode  in  1  level; 1 = program-load mode, fetch blocked
load_we  in  1  write strobe, honoured only in LOAD state
load_addr  in  ADDR_W  write word address
load_data  in  DATA_W  write data
load_count  out  16  words written since last entry to LOAD (saturating)

Behaviour:
- Reset (async, rst_n=0): state=RUN, rsp_valid=0, rsp_instr=0, rsp_fault=0, load_count=0, fetch_ready=0 while rst_n=0. Memory array not reset; power-up init every word = HALT_WORD.
- FSM states RUN, DRAIN, LOAD.
- RUN: fetch_ready = (!rsp_valid || rsp_ready) && !load_mode. On accept, at the next edge: rsp_valid=1, rsp_instr=mem[idx], rsp_fault per bounds rule. Latency is exactly 1 cycle.
- RUN: when rsp_valid && rsp_ready and no new accept, rsp_valid clears next edge.
- Stall: while rsp_valid && !rsp_ready, rsp_instr and rsp_fault hold stable and fetch_ready=0.
- Back-to-back: accepting every cycle with rsp_ready=1 gives one response per cycle.
- RUN -> DRAIN when load_mode=1. No new accepts. If rsp_valid=0, go DRAIN -> LOAD on the next edge; otherwise hold until the pending response is consumed (rsp_valid && rsp_ready), then go LOAD.
- LOAD: on entry, load_count=0. Each cycle with load_we=1 writes mem[idx(load_addr)] and increments load_count, saturating at 16'hFFFF.
- Out-of-range load writes (bounds feature on) are dropped and do not count.
- load_we outside LOAD is ignored.
- LOAD -> RUN when load_mode=0. fetch_ready may assert the same cycle the state reads RUN.
- Read-after-write: a word written in cycle N is returned by a fetch accepted in cycle N+1 or later.
- Index rule: idx = addr[log2(DEPTH)-1:0].
- Reset mid-operation: asynchronous, returns to RUN with outputs per reset; memory contents retained.

Optional Feature:
IMEM_BOUNDS_CHECK_EN
- Defined: fetch_addr >= DEPTH returns rsp_instr=HALT_WORD with rsp_fault=1. Memory is not read. Out-of-range load writes are dropped.
- Undefined: addresses wrap modulo DEPTH via the index rule. rsp_fault is tied to 0 and load writes always land.

Test Plan:
- Reset then idle -> rsp_valid=0, rsp_instr=0, load_count=0; an unloaded fetch of addr 5 returns 16'hF000, fault=0.
- LOAD: write addr0=16'h0298, addr1=16'h5805, addr2=16'hF000; exit; fetch 0,1,2 back-to-back with rsp_ready=1 -> responses 0298, 5805, F000 on consecutive cycles; load_count=3.
- Stall: fetch addr1, hold rsp_ready=0 for 3 cycles -> rsp_instr=5805 held, fetch_ready=0; then rsp_ready=1 -> next accept proceeds.
- load_mode raised while a response is stalled -> stays in DRAIN until consumed; no accepts while load_mode=1; load_we in DRAIN ignored.
- Fetch addr 512 (DEPTH=512): with macro -> F000, fault=1; without macro -> returns mem[0]=0298, fault=0.
- rst_n low mid-LOAD after 2 writes -> outputs reset immediately; written words still readable after reset.
